bin_dot_accum: RTL

Parametrised binary-weight dot-product engine with a registered adder tree and multi-beat accumulation. It is the successor to the fixed 16-lane multiply/adder-tree block. Each accepted beat multiplies `LANES` signed inputs by ±1 weights, reduces them through a pipelined tree, and accumulates across beats until `in_last`. The block then presents one neuron pre-activation result through a valid/ready output. It sits between the input-neuron buffer and the activation stage of the accelerator.

---
 rtl/bin_dot_accum.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/bin_dot_accum.sv
// Binary-weight (+/-1) dot-product engine: per-lane sign stage, registered adder
// tree and multi-beat accumulator. Define BIN_DOT_SAT_EN for the saturating build.

module bin_dot_lane #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 32
) (
  input  logic [DATA_W-1:0] x,
  input  logic              w,
  output logic [ACC_W-1:0]  p
);
  logic [ACC_W-1:0] ext;

  // Negate after widening so -2^(DATA_W-1) stays exact.
  assign ext = {{(ACC_W-DATA_W){x[DATA_W-1]}}, x};
  assign p   = w ? ext : -ext;
endmodule

module bin_dot_accum #(
  parameter int LANES  = 16,
  parameter int DATA_W = 16,
  parameter int ACC_W  = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [LANES-1:0][DATA_W-1:0] in_data,
  input  logic [LANES-1:0]             in_weights,
  input  logic                         in_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_W-1:0]            out_data,
  output logic                         out_ovf
);
  localparam int L     = $clog2(LANES);
  localparam int NODES = 2*LANES - 1;

  // Tree nodes stored level by level: level k starts at 2*LANES - 2*(LANES>>k).
  logic [LANES-1:0][ACC_W-1:0] prod;
  logic [NODES-1:0][ACC_W-1:0] node_nxt, node_d, node_q;
  logic [L:0]                  vld_pipe_d, vld_pipe_q, last_pipe_d, last_pipe_q;
  logic [ACC_W-1:0]            acc_d, acc_q, sum;
  logic [DATA_W-1:0]           out_data_d, out_data_q, conv_data;
  logic                        out_valid_d, out_valid_q;
  logic                        adv;

  bin_dot_lane #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_lane [LANES-1:0] (
    .x (in_data),
    .w (in_weights),
    .p (prod)
  );

  for (genvar i = 0; i < LANES; i++) begin : g_s0
    assign node_nxt[i] = prod[i];
  end

  for (genvar k = 1; k <= L; k++) begin : g_lvl
    localparam int OFF  = 2*LANES - 2*(LANES >> k);
    localparam int POFF = 2*LANES - 2*(LANES >> (k-1));
    for (genvar i = 0; i < (LANES >> k); i++) begin : g_add
      assign node_nxt[OFF+i] = node_q[POFF+2*i] + node_q[POFF+2*i+1];
    end
  end

  assign sum = acc_q + node_q[NODES-1];

`ifdef BIN_DOT_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
  logic conv_ovf, out_ovf_d, out_ovf_q;

  always_comb begin
    conv_ovf  = 1'b0;
    conv_data = sum[DATA_W-1:0];
    if ($signed(sum) > SAT_MAX) begin
      conv_ovf  = 1'b1;
      conv_data = SAT_MAX[DATA_W-1:0];
    end else if ($signed(sum) < SAT_MIN) begin
      conv_ovf  = 1'b1;
      conv_data = SAT_MIN[DATA_W-1:0];
    end
  end

  always_comb begin
    out_ovf_d = out_ovf_q;
    if (adv && vld_pipe_q[L] && last_pipe_q[L]) out_ovf_d = conv_ovf;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) out_ovf_q <= 1'b0;
    else     out_ovf_q <= out_ovf_d;
  end

  assign out_ovf = out_ovf_q;
`else
  assign conv_data = sum[DATA_W-1:0];
  assign out_ovf   = 1'b0;
`endif

  // One stall point: a held result freezes the whole pipe, accumulator included.
  assign adv = !(out_valid_q && !out_ready);

  always_comb begin
    node_d      = node_q;
    vld_pipe_d  = vld_pipe_q;
    last_pipe_d = last_pipe_q;
    acc_d       = acc_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q && !out_ready;
    if (adv) begin
      node_d      = node_nxt;
      vld_pipe_d  = {vld_pipe_q[L-1:0], in_valid};
      last_pipe_d = {last_pipe_q[L-1:0], in_valid && in_last};
      if (vld_pipe_q[L]) begin
        if (last_pipe_q[L]) begin
          acc_d       = '0;
          out_data_d  = conv_data;
          out_valid_d = 1'b1;
        end else begin
          acc_d = sum;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      node_q      <= '0;
      vld_pipe_q  <= '0;
      last_pipe_q <= '0;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      node_q      <= node_d;
      vld_pipe_q  <= vld_pipe_d;
      last_pipe_q <= last_pipe_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = adv;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
endmodule
